// File: rtl/multicycle_alu_pkg.sv
// Shared ALU operation codes and FSM state encoding for the multicycle ALU
// and the ALU-control decoder.
package multicycle_alu_pkg;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;
    localparam logic [2:0] ALU_SLL = 3'b011;
    localparam logic [2:0] ALU_SRA = 3'b100;
    localparam logic [2:0] ALU_SRL = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    function automatic logic is_shift_op(input logic [2:0] op);
        return (op == ALU_SLL) || (op == ALU_SRA) || (op == ALU_SRL);
    endfunction

endpackage

// File: rtl/multicycle_alu_shift_step.sv
// Combinational single-bit shifter: moves din one position in the direction
// and with the fill selected by the shift op code.
module shift_step
    import multicycle_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    always_comb begin
        dout = din;
        case (op)
            ALU_SLL: dout = {din[WIDTH-2:0], 1'b0};
            ALU_SRA: dout = {din[WIDTH-1], din[WIDTH-1:1]};
            ALU_SRL: dout = {1'b0, din[WIDTH-1:1]};
            default: dout = din;
        endcase
    end

endmodule

// File: rtl/multicycle_alu.sv
// Multicycle ALU: single-cycle logic/arithmetic ops, shifts done one bit per
// cycle, with valid/ready handshakes on both the request and result sides.
module multicycle_alu
    import multicycle_alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       alucontrol,
    input  logic             shift,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [SHW-1:0]   shamt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             busy
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [SHW-1:0]   count_q, count_d;
    logic [2:0]       op_q, op_d;
    logic             out_valid_q, out_valid_d;
    logic             in_ready_q, in_ready_d;
    logic             busy_q, busy_d;
    logic             zero_q, zero_d;

    logic [WIDTH-1:0] alu_value;
    logic [WIDTH-1:0] step_value;
    logic [SHW-1:0]   req_count;

    shift_step #(.WIDTH(WIDTH)) u_shift_step (
        .op   (op_q),
        .din  (result_q),
        .dout (step_value)
    );

    assign req_count = shift ? shamt : a[SHW-1:0];

    always_comb begin
        alu_value = '0;
        case (alucontrol)
            ALU_AND: alu_value = a & b;
            ALU_OR:  alu_value = a | b;
            ALU_ADD: alu_value = a + b;
            ALU_SUB: alu_value = a - b;
            ALU_SLT: alu_value = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            default: alu_value = '0;
        endcase
    end

    // result_q doubles as the shift working register while in ST_SHIFT.
    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        count_d  = count_q;
        op_d     = op_q;
        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    op_d = alucontrol;
                    if (is_shift_op(alucontrol)) begin
                        result_d = b;
                        count_d  = req_count;
                        state_d  = (req_count == '0) ? ST_DONE : ST_SHIFT;
                    end else begin
                        result_d = alu_value;
                        state_d  = ST_DONE;
                    end
                end
            end
            ST_SHIFT: begin
                result_d = step_value;
                count_d  = count_q - SHW'(1);
                if (count_q == SHW'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        out_valid_d = (state_d == ST_DONE);
        in_ready_d  = (state_d == ST_IDLE);
        busy_d      = (state_d != ST_IDLE);
        zero_d      = (result_d == '0);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            result_q    <= '0;
            count_q     <= '0;
            op_q        <= ALU_AND;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            zero_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            result_q    <= result_d;
            count_q     <= count_d;
            op_q        <= op_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
            zero_q      <= zero_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign zero      = zero_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_multicycle_alu.sv
// Self-checking bench for multicycle_alu: directed corner cases plus random
// operations compared against a plain-arithmetic reference model.
module tb_multicycle_alu;
    import multicycle_alu_pkg::*;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  alucontrol = 3'b000;
    logic        shift = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [4:0]  shamt = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic        zero;
    logic        busy;

    int checkCount = 0;
    int errorCount = 0;

    multicycle_alu #(.WIDTH(32), .SHW(5)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .alucontrol (alucontrol),
        .shift      (shift),
        .a          (a),
        .b          (b),
        .shamt      (shamt),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .zero       (zero),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: the final answer of each operation as plain arithmetic.
    function automatic logic [31:0] modelResult(input logic [2:0] op, input logic [31:0] av,
                                                input logic [31:0] bv, input int k);
        logic signed [31:0] sb;
        sb = bv;
        case (op)
            ALU_AND: return av & bv;
            ALU_OR:  return av | bv;
            ALU_ADD: return av + bv;
            ALU_SUB: return av - bv;
            ALU_SLT: return ($signed(av) < $signed(bv)) ? 32'd1 : 32'd0;
            ALU_SLL: return bv << k;
            ALU_SRL: return bv >> k;
            ALU_SRA: return sb >>> k;
            default: return 32'd0;
        endcase
    endfunction

    function automatic int modelLatency(input logic [2:0] op, input int k);
        if ((op == ALU_SLL || op == ALU_SRA || op == ALU_SRL) && k > 0) return k + 1;
        return 1;
    endfunction

    task automatic scrambleInputs();
        alucontrol = 3'($urandom);
        shift      = 1'($urandom);
        a          = $urandom;
        b          = $urandom;
        shamt      = 5'($urandom);
    endtask

    // Present a request in IDLE and leave the bench just after the accept edge.
    task automatic driveRequest(input logic [2:0] op, input logic sh, input logic [31:0] av,
                                input logic [31:0] bv, input logic [4:0] sa);
        @(negedge clk);
        checkOutput("in_ready_idle", {31'd0, in_ready}, 32'd1);
        in_valid   = 1'b1;
        out_ready  = 1'b0;
        alucontrol = op;
        shift      = sh;
        a          = av;
        b          = bv;
        shamt      = sa;
        @(posedge clk);
    endtask

    // Full transaction: accept, wait for the result, stall for hold cycles, handshake.
    task automatic applyStimulus(input logic [2:0] op, input logic sh, input logic [31:0] av,
                                 input logic [31:0] bv, input logic [4:0] sa, input int hold);
        int k;
        int cycles;
        logic [31:0] expRes;
        k = sh ? int'(sa) : int'(av[4:0]);
        expRes = modelResult(op, av, bv, k);
        driveRequest(op, sh, av, bv, sa);
        @(negedge clk);
        in_valid = 1'b0;
        scrambleInputs();
        cycles = 1;
        while (!out_valid && cycles <= 40) begin
            checkOutput("in_ready_busy", {31'd0, in_ready}, 32'd0);
            checkOutput("busy_high", {31'd0, busy}, 32'd1);
            in_valid  = 1'($urandom);
            out_ready = 1'($urandom);
            scrambleInputs();
            @(negedge clk);
            cycles++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        checkOutput("out_valid", {31'd0, out_valid}, 32'd1);
        if (out_valid) begin
            checkOutput("latency", 32'(cycles), 32'(modelLatency(op, k)));
            checkOutput("result", result, expRes);
            checkOutput("zero", {31'd0, zero}, {31'd0, expRes == 32'd0});
            for (int i = 0; i < hold; i++) begin
                in_valid = 1'($urandom);
                @(negedge clk);
                checkOutput("hold_result", result, expRes);
                checkOutput("hold_valid", {31'd0, out_valid}, 32'd1);
                checkOutput("hold_in_ready", {31'd0, in_ready}, 32'd0);
            end
            out_ready = 1'b1;
            in_valid  = 1'($urandom);
            @(negedge clk);
            out_ready = 1'b0;
            in_valid  = 1'b0;
            checkOutput("post_hs_valid", {31'd0, out_valid}, 32'd0);
            checkOutput("post_hs_busy", {31'd0, busy}, 32'd0);
        end
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
        checkOutput({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd0);
        checkOutput({tag, "_result"}, result, 32'd0);
        checkOutput({tag, "_zero"}, {31'd0, zero}, 32'd1);
    endtask

    // Accept a request, reset after waitCycles, and confirm nothing ever completes.
    task automatic resetInFlight(input logic [2:0] op, input logic sh, input logic [31:0] av,
                                 input logic [31:0] bv, input logic [4:0] sa, input int waitCycles);
        logic seen;
        driveRequest(op, sh, av, bv, sa);
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 1; i < waitCycles; i++) @(negedge clk);
        resetn = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        resetn = 1'b1;
        out_ready = 1'b0;
        checkResetState("mid_reset");
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        checkOutput("no_out_valid_after_reset", {31'd0, seen}, 32'd0);
    endtask

    initial begin
        logic [2:0] ops [8];
        ops = '{ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_SLL, ALU_SRA, ALU_SRL};

        resetn = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        checkResetState("reset");

        applyStimulus(ALU_ADD, 1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 5'd0, 0);
        applyStimulus(ALU_SUB, 1'b0, 32'd5, 32'd5, 5'd0, 0);
        applyStimulus(ALU_SLT, 1'b0, 32'hFFFF_FFFF, 32'd1, 5'd0, 0);
        applyStimulus(ALU_SLT, 1'b0, 32'd1, 32'hFFFF_FFFF, 5'd0, 1);
        applyStimulus(ALU_SRA, 1'b1, 32'd0, 32'h8000_0000, 5'd4, 0);
        applyStimulus(ALU_SRL, 1'b0, 32'h0000_0023, 32'h8000_0000, 5'd0, 3);
        applyStimulus(ALU_SLL, 1'b1, 32'd0, 32'h0000_1234, 5'd0, 1);
        applyStimulus(ALU_SLL, 1'b1, 32'd0, 32'h0000_0001, 5'd31, 0);
        applyStimulus(ALU_AND, 1'b0, 32'hF0F0_1234, 32'h0FF0_FFFF, 5'd0, 2);
        applyStimulus(ALU_OR,  1'b0, 32'h0000_0000, 32'h0000_0000, 5'd0, 0);

        for (int n = 0; n < 40; n++) begin
            applyStimulus(ops[$urandom_range(7)], 1'($urandom), $urandom, $urandom,
                          5'($urandom), int'($urandom_range(3)));
        end

        resetInFlight(ALU_SLL, 1'b1, 32'd0, 32'd1, 5'd31, 10);
        applyStimulus(ALU_ADD, 1'b0, 32'd2, 32'd3, 5'd0, 0);
        resetInFlight(ALU_ADD, 1'b0, 32'd7, 32'd9, 5'd0, 1);
        applyStimulus(ALU_SRL, 1'b1, 32'd0, 32'hFFFF_FFFF, 5'd31, 1);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
